// File: rtl/prog_loader.sv
// prog_loader: boot-time loader that assembles a big-endian byte stream into
// 16-bit words, writes them to the unified memory from START_ADDR upward and
// holds the processor in reset until the whole image is in place.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require a trailing
// 16-bit checksum (modulo-2^16 sum of the image words) before release.
module prog_loader #(
    parameter int unsigned DEPTH      = 20,
    parameter int unsigned START_ADDR = 0,
    localparam int unsigned W         = 16,
    localparam int unsigned BW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [BW-1:0] rx_data,
    output logic          rx_ready,
    output logic          mem_we,
    output logic [W-1:0]  mem_addr,
    output logic [W-1:0]  mem_wdata,
    output logic          cpu_reset,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  word_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM_HI,
        S_CSUM_LO,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // State entered once the image (or an empty image) has been consumed.
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM_HI;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t         state;
    logic [W-1:0]   len_q;
    logic [BW-1:0]  hi_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [W-1:0]   sum_q;
    logic [BW-1:0]  csum_hi_q;
`endif

    logic           xfer;
    logic [W-1:0]   len_in;
    logic [W-1:0]   word_in;
    logic           last_word;

    assign xfer      = rx_valid & rx_ready;
    assign len_in    = {len_q[W-1:BW], rx_data};
    assign word_in   = {hi_q, rx_data};
    assign last_word = (W'(word_count + W'(1)) == len_q);

    // Byte acceptance is a pure decode of the current state.
    always_comb begin
        rx_ready = 1'b0;
        case (state)
            S_LEN_HI:  rx_ready = 1'b1;
            S_LEN_LO:  rx_ready = 1'b1;
            S_DATA_HI: rx_ready = 1'b1;
            S_DATA_LO: rx_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM_HI: rx_ready = 1'b1;
            S_CSUM_LO: rx_ready = 1'b1;
`endif
            default:   rx_ready = 1'b0;
        endcase
    end

    // Load sequencer with registered memory-write and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            len_q      <= '0;
            hi_q       <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= W'(START_ADDR);
            mem_wdata  <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            csum_hi_q  <= '0;
`endif
        end else begin
            mem_we    <= 1'b0;
            done      <= (state == S_DONE);
            err       <= (state == S_ERR);
            cpu_reset <= (state != S_DONE);
            case (state)
                S_IDLE: begin
                    word_count <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_q      <= '0;
`endif
                    state      <= S_LEN_HI;
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_q[W-1:BW] <= rx_data;
                        state         <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_q[BW-1:0] <= rx_data;
                        if (len_in == '0) begin
                            state <= S_TAIL;
                        end else if (17'(len_in) > 17'(DEPTH)) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (xfer) begin
                        hi_q  <= rx_data;
                        state <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (xfer) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= W'(W'(START_ADDR) + word_count);
                        mem_wdata  <= word_in;
                        word_count <= W'(word_count + W'(1));
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_q      <= W'(sum_q + word_in);
`endif
                        state      <= last_word ? S_TAIL : S_DATA_HI;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CSUM_HI: begin
                    if (xfer) begin
                        csum_hi_q <= rx_data;
                        state     <= S_CSUM_LO;
                    end
                end
                S_CSUM_LO: begin
                    if (xfer) begin
                        state <= ({csum_hi_q, rx_data} == sum_q) ? S_DONE : S_ERR;
                    end
                end
`endif
                S_DONE: state <= S_DONE;
                S_ERR:  state <= S_ERR;
                default: state <= S_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized image loads checked against a
// byte-stream/write-list reference model kept in the bench.
module tb_prog_loader;

    localparam int unsigned DEPTH = 20;
    localparam int unsigned START = 0;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    prog_loader #(.DEPTH(DEPTH), .START_ADDR(START)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          done_cyc = -1;
    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          wr_cyc[$];
    logic [15:0] img[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and record what the DUT shows there.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc = -1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
        check({tag, "_mem_we"},     32'(mem_we),     32'd0);
        check({tag, "_mem_addr"},   32'(mem_addr),   START);
        check({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
        check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    // gmode: 0 = back-to-back, 1 = valid every other cycle, 2 = random gaps
    function automatic int gap_for(input int gmode);
        if (gmode == 1) return 1;
        if (gmode == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    task automatic send_byte(input string tag, input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 20; t++) begin
            ok = (rx_ready === 1'b1);
            step();
            if (ok) break;
        end
        if (!ok) check({tag, "_byte_accepted"}, 32'(ok), 32'd1);
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            step();
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        rx_valid = 1'b0;
        step();
        step();
        clear_log();
        reset = 1'b1;
    endtask

    // Stream an image of n words from img[] and check writes and final status.
    task automatic run_load(input string tag, input int n, input int gmode, input bit csum_bad);
        logic [15:0] nn;
        logic [15:0] sum;
        logic [15:0] cs;
        bit          exp_err;
        int          exp_wr;
        int          wc_end;
        int          wr_end;
        nn  = 16'(n);
        sum = 16'd0;
        send_byte(tag, nn[15:8], gap_for(gmode));
        send_byte(tag, nn[7:0], gap_for(gmode));
        if (n <= int'(DEPTH)) begin
            for (int i = 0; i < n; i++) begin
                send_byte(tag, img[i][15:8], gap_for(gmode));
                send_byte(tag, img[i][7:0], gap_for(gmode));
                sum = 16'(sum + img[i]);
            end
            if (CSUM_ON) begin
                cs = csum_bad ? (sum ^ 16'h0001) : sum;
                send_byte(tag, cs[15:8], gap_for(gmode));
                send_byte(tag, cs[7:0], gap_for(gmode));
            end
        end
        rx_valid = 1'b0;
        exp_err = (n > int'(DEPTH)) || (CSUM_ON && csum_bad);
        exp_wr  = (n > int'(DEPTH)) ? 0 : n;

        for (int t = 0; t < 10 && !(done === 1'b1 || err === 1'b1); t++) step();
        step();
        check({tag, "_done"},      32'(done),       32'(!exp_err));
        check({tag, "_err"},       32'(err),        32'(exp_err));
        check({tag, "_cpu_reset"}, 32'(cpu_reset),  32'(exp_err));
        check({tag, "_wcount"},    32'(word_count), 32'(exp_wr));
        check({tag, "_rx_ready"},  32'(rx_ready),   32'd0);
        check({tag, "_nwrites"},   32'(wr_addr.size()), 32'(exp_wr));
        for (int i = 0; i < exp_wr && i < wr_addr.size(); i++) begin
            check({tag, "_addr"}, 32'(wr_addr[i]), 32'(16'(START + i)));
            check({tag, "_data"}, 32'(wr_data[i]), 32'(img[i]));
        end
        if (gmode == 0 && !exp_err && exp_wr > 0 && wr_cyc.size() == exp_wr) begin
            for (int i = 1; i < exp_wr; i++)
                check({tag, "_spacing"}, 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd2);
            check({tag, "_release_lat"}, 32'(done_cyc - wr_cyc[exp_wr-1]),
                  CSUM_ON ? 32'd3 : 32'd1);
        end

        // Bytes offered after the terminal state must be ignored.
        wc_end = int'(word_count);
        wr_end = wr_addr.size();
        rx_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            rx_data = 8'($urandom);
            step();
        end
        rx_valid = 1'b0;
        check({tag, "_post_writes"}, 32'(wr_addr.size()), 32'(wr_end));
        check({tag, "_post_wcount"}, 32'(word_count),      32'(wc_end));
        check({tag, "_post_ready"},  32'(rx_ready),        32'd0);
        check({tag, "_post_err"},    32'(err),             32'(exp_err));
    endtask

    initial begin
        int n;
        int sel;
        int gm;
        bit bad;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        step();
        step();
        step();
        check_reset_vals("rst");
        reset = 1'b1;
        clear_log();
        step();
        check("ready_after_release", 32'(rx_ready), 32'd1);

        // Directed image, back-to-back bytes.
        img = '{16'h1234, 16'hA1C0, 16'h0042};
        run_load("t1", 3, 0, 1'b0);

        // Same image, valid toggled every other cycle.
        do_reset();
        run_load("t2", 3, 1, 1'b0);

        // Length beyond the memory depth aborts the load.
        do_reset();
        run_load("t3", 21, 0, 1'b0);

        // Reset after the second data word, then a fresh single-word image.
        do_reset();
        img = '{16'h1111, 16'h2222, 16'h3333};
        send_byte("t4p", 8'h00, 0);
        send_byte("t4p", 8'h03, 0);
        for (int i = 0; i < 2; i++) begin
            send_byte("t4p", img[i][15:8], 0);
            send_byte("t4p", img[i][7:0], 0);
        end
        rx_valid = 1'b0;
        reset = 1'b0;
        step();
        check_reset_vals("t4_rst");
        reset = 1'b1;
        clear_log();
        img = '{16'hBEEF};
        run_load("t4", 1, 0, 1'b0);

        // Empty image.
        do_reset();
        img.delete();
        run_load("t5", 0, 0, 1'b0);

        if (CSUM_ON) begin
            do_reset();
            img = '{16'h0001, 16'hFFFF};
            run_load("t6_good", 2, 0, 1'b0);
            do_reset();
            run_load("t6_bad", 2, 0, 1'b1);
        end

        // Randomized images, lengths and pacing.
        for (int it = 0; it < 12; it++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      n = 0;
            else if (sel == 1) n = int'(DEPTH) + int'($urandom_range(1, 300));
            else if (sel == 2) n = int'(DEPTH);
            else               n = int'($urandom_range(1, DEPTH));
            gm  = int'($urandom_range(0, 2));
            bad = CSUM_ON && ($urandom_range(0, 3) == 0);
            img.delete();
            for (int i = 0; i < n && i < int'(DEPTH); i++) img.push_back(16'($urandom));
            do_reset();
            run_load("rnd", n, gm, bad);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
